main_memory_responder: RTL and testbench

MAIN_MEMORY_RESPONDER -- requirements
Module: main_memory_responder

---
 rtl/main_memory_responder.sv | 135 +++++++++++++
 tb/tb_main_memory_responder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/main_memory_responder.sv
// main_memory_responder: responder side of the cache-controller memory
// interface, modelling a wait-stated main memory of 2^ADDR_W x DATA_W words.
//
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   MStrobe   request strobe; a request is a rising edge of this signal
//   MRW       request direction (0 = read, 1 = write)
//   MAddr     word address
//   MWrData   write data
//   MRdData   registered read data, held until the next read completes
//   MReady    one-cycle access-complete pulse
//   MBusy     high while a request is in flight
//   MOverrun  one-cycle pulse when a strobe rising edge is dropped
module main_memory_responder #(
    parameter int unsigned ADDR_W      = 10,
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              MStrobe,
    input  logic              MRW,
    input  logic [ADDR_W-1:0] MAddr,
    input  logic [DATA_W-1:0] MWrData,
    output logic [DATA_W-1:0] MRdData,
    output logic              MReady,
    output logic              MBusy,
    output logic              MOverrun
);

    localparam int unsigned DEPTH = 1 << ADDR_W;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] WAIT_LOAD = CNT_W'(WAIT_CYCLES);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2,
        READY  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic               strobe_q;
    logic               rise_c;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               rw_q, rw_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [DATA_W-1:0]  wdata_q, wdata_d;
    logic               ready_d, busy_d, overrun_d;

    // Storage array; deliberately not reset.
    logic [DATA_W-1:0]  mem [DEPTH];

    assign rise_c = MStrobe & ~strobe_q;

    // Next-state, request capture and output decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rw_d      = rw_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        overrun_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (rise_c) begin
                    rw_d    = MRW;
                    addr_d  = MAddr;
                    wdata_d = MWrData;
                    cnt_d   = WAIT_LOAD;
                    state_d = (WAIT_LOAD != '0) ? WAIT : ACCESS;
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
                // A zero count cannot occur here; leaving on it avoids a lockup.
                if (cnt_q <= CNT_W'(1)) begin
                    state_d = ACCESS;
                end
            end
            ACCESS: state_d = READY;
            READY:  state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Busy covers every non-IDLE state, so any rise there is dropped.
        if (rise_c && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        ready_d = (state_d == READY);
        busy_d  = (state_d != IDLE);
    end

    // State, request registers and registered outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            strobe_q <= 1'b0;
            cnt_q    <= '0;
            rw_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            MReady   <= 1'b0;
            MBusy    <= 1'b0;
            MOverrun <= 1'b0;
            MRdData  <= '0;
        end else begin
            state_q  <= state_d;
            strobe_q <= MStrobe;
            cnt_q    <= cnt_d;
            rw_q     <= rw_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            MReady   <= ready_d;
            MBusy    <= busy_d;
            MOverrun <= overrun_d;
            if ((state_q == ACCESS) && !rw_q) begin
                MRdData <= mem[addr_q];
            end
        end
    end

    // Write commit at the end of ACCESS; a coincident reset aborts it.
    always_ff @(posedge clk) begin
        if (!reset && (state_q == ACCESS) && rw_q) begin
            mem[addr_q] <= wdata_q;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// Testbench for main_memory_responder: instance a uses WAIT_CYCLES=4,
// instance b uses WAIT_CYCLES=0. Table-driven accesses plus directed
// sequences for overrun, held strobe and reset abort.
module tb_main_memory_responder;

    logic        clk;
    logic        reset;

    logic        a_strobe, a_rw;
    logic [9:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        a_ready, a_busy, a_overrun;

    logic        b_strobe, b_rw;
    logic [9:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic        b_ready, b_busy, b_overrun;

    int errors = 0;
    int checks = 0;

    main_memory_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(4)) dut_a (
        .clk(clk), .reset(reset), .MStrobe(a_strobe), .MRW(a_rw), .MAddr(a_addr),
        .MWrData(a_wdata), .MRdData(a_rdata), .MReady(a_ready), .MBusy(a_busy),
        .MOverrun(a_overrun)
    );

    main_memory_responder #(.ADDR_W(10), .DATA_W(32), .WAIT_CYCLES(0)) dut_b (
        .clk(clk), .reset(reset), .MStrobe(b_strobe), .MRW(b_rw), .MAddr(b_addr),
        .MWrData(b_wdata), .MRdData(b_rdata), .MReady(b_ready), .MBusy(b_busy),
        .MOverrun(b_overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          sel;
        logic        rw;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(input int sel, input logic stb, input logic rw,
                         input logic [9:0] addr, input logic [31:0] data);
        if (sel == 0) begin
            a_strobe = stb; a_rw = rw; a_addr = addr; a_wdata = data;
        end else begin
            b_strobe = stb; b_rw = rw; b_addr = addr; b_wdata = data;
        end
    endtask

    function automatic logic get_ready(input int sel);
        return (sel == 0) ? a_ready : b_ready;
    endfunction

    function automatic logic get_busy(input int sel);
        return (sel == 0) ? a_busy : b_busy;
    endfunction

    function automatic logic [31:0] get_rd(input int sel);
        return (sel == 0) ? a_rdata : b_rdata;
    endfunction

    // One complete access; latency is the edge count from the accepting edge
    // to the edge that first samples MReady high (WAIT_CYCLES + 2).
    task automatic access(input int sel, input logic rw, input logic [9:0] addr,
                          input logic [31:0] data, input logic [31:0] exp_rd,
                          input string tag);
        int          lat;
        int          exp_lat;
        logic [31:0] rd_before;
        logic        held;
        exp_lat = (sel == 0) ? 6 : 2;
        @(negedge clk);
        rd_before = get_rd(sel);
        held = 1'b1;
        drive(sel, 1'b1, rw, addr, data);
        @(posedge clk);
        lat = -1;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (k == 0) begin
                // Scramble request inputs after acceptance.
                drive(sel, 1'b0, ~rw, ~addr, ~data);
                chk({tag, " busy"}, 32'(get_busy(sel)), 32'd1);
            end
            if (rw && (get_rd(sel) !== rd_before)) held = 1'b0;
            if (get_ready(sel)) begin
                lat = k + 1;
                break;
            end
        end
        chk({tag, " latency"}, 32'(lat), 32'(exp_lat));
        if (rw) chk({tag, " rdata held"}, 32'(held), 32'd1);
        else    chk({tag, " rdata"}, get_rd(sel), exp_rd);
        @(negedge clk);
        chk({tag, " ready width"}, 32'(get_ready(sel)), 32'd0);
        chk({tag, " busy cleared"}, 32'(get_busy(sel)), 32'd0);
    endtask

    initial begin
        int n_rdy;
        int n_ovr;

        vecs[0] = '{0, 1'b1, 10'h005, 32'hDEADBEEF, 32'h0};
        vecs[1] = '{0, 1'b0, 10'h005, 32'h0,        32'hDEADBEEF};
        vecs[2] = '{0, 1'b1, 10'h001, 32'h00000011, 32'h0};
        vecs[3] = '{0, 1'b0, 10'h001, 32'h0,        32'h00000011};
        vecs[4] = '{0, 1'b1, 10'h002, 32'h00000022, 32'h0};
        vecs[5] = '{0, 1'b1, 10'h010, 32'h00000000, 32'h0};
        vecs[6] = '{0, 1'b1, 10'h021, 32'h00000055, 32'h0};
        vecs[7] = '{1, 1'b1, 10'h3FF, 32'h12345678, 32'h0};
        vecs[8] = '{1, 1'b0, 10'h3FF, 32'h0,        32'h12345678};
        vecs[9] = '{0, 1'b0, 10'h002, 32'h0,        32'h00000022};

        reset = 1'b1;
        drive(0, 1'b0, 1'b0, 10'h0, 32'h0);
        drive(1, 1'b0, 1'b0, 10'h0, 32'h0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        chk("reset a ready",   32'(a_ready),   32'd0);
        chk("reset a busy",    32'(a_busy),    32'd0);
        chk("reset a overrun", 32'(a_overrun), 32'd0);
        chk("reset a rdata",   a_rdata,        32'd0);
        chk("reset b rdata",   b_rdata,        32'd0);
        chk("reset b busy",    32'(b_busy),    32'd0);

        for (int i = 0; i < 10; i++) begin
            access(vecs[i].sel, vecs[i].rw, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, $sformatf("vec%0d", i));
        end

        // Overrun: second rise two cycles after acceptance is dropped.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 10'h020, 32'hAAAAAAAA);
        @(posedge clk);
        @(negedge clk);
        a_strobe = 1'b0;
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 10'h021, 32'hBBBBBBBB);
        @(negedge clk);
        chk("overrun pulse", 32'(a_overrun), 32'd1);
        a_strobe = 1'b0;
        n_rdy = 0;
        n_ovr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 0) chk("overrun width", 32'(a_overrun), 32'd0);
            if (a_ready) n_rdy++;
        end
        chk("overrun ready count", 32'(n_rdy), 32'd1);
        access(0, 1'b0, 10'h021, 32'h0, 32'h00000055, "overrun addr2");
        access(0, 1'b0, 10'h020, 32'h0, 32'hAAAAAAAA, "overrun addr1");

        // Held strobe: one access only, no overrun.
        @(negedge clk);
        drive(0, 1'b1, 1'b0, 10'h001, 32'h0);
        n_rdy = 0;
        n_ovr = 0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (k == 9) a_strobe = 1'b0;
            if (a_ready) n_rdy++;
            if (a_overrun) n_ovr++;
        end
        chk("held ready count", 32'(n_rdy), 32'd1);
        chk("held overrun count", 32'(n_ovr), 32'd0);
        chk("held rdata", a_rdata, 32'h00000011);
        access(0, 1'b0, 10'h005, 32'h0, 32'hDEADBEEF, "after held");

        // Reset during WAIT aborts the write.
        @(negedge clk);
        drive(0, 1'b1, 1'b1, 10'h010, 32'hA5A5A5A5);
        @(posedge clk);
        @(negedge clk);
        a_strobe = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("abort busy", 32'(a_busy), 32'd0);
        n_rdy = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (a_ready) n_rdy++;
        end
        chk("abort ready count", 32'(n_rdy), 32'd0);
        access(0, 1'b0, 10'h010, 32'h0, 32'h00000000, "abort readback");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
